// File: rtl/bus_timer_responder.sv
// ---------------------------------------------------------------------------
// bus_timer_responder
//
// Memory-mapped 16-bit down-counter timer that sits on the processor memory
// bus as a responder. Reads are answered combinationally on the shared data
// bus, writes are committed on the rising clock edge, and an expiry raises
// either a maskable (irq) or non-maskable (nmi) level interrupt.
//
// Register window (8 bytes at BASE_ADDR):
//   0 CTRL       R/W  bit0 EN, bit1 AUTO, bit2 IEN, bit3 NSEL, bit4 WDOG
//   1 PRESCALE   R/W
//   2 RELOAD_LO  R/W
//   3 RELOAD_HI  R/W
//   4 COUNT_LO   read: count[7:0] and snapshot count[15:8]; write: reload
//   5 COUNT_HI   RO   snapshot taken by the last COUNT_LO read
//   6 STATUS     W1C  bit0 EXP (sticky), bit1 OVF
//   7 ID         RO   ID_VALUE
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   clk_en   global clock enable qualifying every state update
//   addr     processor address bus
//   data     shared bidirectional data bus, driven only on a selected read
//   wr       processor write strobe (1 = write, 0 = read)
//   irq      maskable interrupt request (level)
//   nmi      non-maskable interrupt request (level)
//   rst_req  watchdog reset request (one enabled cycle pulse)
//
// Build option:
//   BUS_TIMER_WATCHDOG_EN  when defined, CTRL.WDOG becomes a set-only bit and
//                          an expiry with WDOG set pulses rst_req one enabled
//                          cycle later. When undefined, WDOG reads 0 and
//                          rst_req is tied low.
// ---------------------------------------------------------------------------
module bus_timer_responder #(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter logic [7:0]  ID_VALUE  = 8'hC7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [15:0] addr,
    inout  wire  [7:0]  data,
    input  logic        wr,
    output logic        irq,
    output logic        nmi,
    output logic        rst_req
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_RELOADLO = 3'd2;
    localparam logic [2:0] OFF_RELOADHI = 3'd3;
    localparam logic [2:0] OFF_COUNTLO  = 3'd4;
    localparam logic [2:0] OFF_COUNTHI  = 3'd5;
    localparam logic [2:0] OFF_STATUS   = 3'd6;
    localparam logic [2:0] OFF_ID       = 3'd7;

    // Bus decode
    logic       sel;
    logic       rdSel;
    logic       wrSel;
    logic [2:0] offset;
    logic [7:0] wrData;
    logic [7:0] rdData;

    logic ctrlWr;
    logic prescaleWr;
    logic reloadLoWr;
    logic reloadHiWr;
    logic countLoWr;
    logic statusWr;
    logic countLoRd;

    // Architectural state
    logic        en_q,       en_d;
    logic        auto_q,     auto_d;
    logic        ien_q,      ien_d;
    logic        nsel_q,     nsel_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  reloadLo_q, reloadLo_d;
    logic [7:0]  reloadHi_q, reloadHi_d;
    logic [15:0] count_q,    count_d;
    logic [7:0]  snap_q,     snap_d;
    logic        exp_q,      exp_d;
    logic        ovf_q,      ovf_d;
    logic [7:0]  preCnt_q,   preCnt_d;

    // Internal events of the current enabled edge
    logic tick;
    logic tickLive;
    logic expiry;
    logic wdogBit;

    assign sel    = (addr[15:3] == BASE_ADDR[15:3]);
    assign rdSel  = sel & ~wr;
    assign wrSel  = sel & wr;
    assign offset = addr[2:0];
    assign wrData = data;

    assign ctrlWr     = wrSel && (offset == OFF_CTRL);
    assign prescaleWr = wrSel && (offset == OFF_PRESCALE);
    assign reloadLoWr = wrSel && (offset == OFF_RELOADLO);
    assign reloadHiWr = wrSel && (offset == OFF_RELOADHI);
    assign countLoWr  = wrSel && (offset == OFF_COUNTLO);
    assign statusWr   = wrSel && (offset == OFF_STATUS);
    assign countLoRd  = rdSel && (offset == OFF_COUNTLO);

    // The data bus is released whenever this block is not the read target.
    assign data = rdSel ? rdData : 8'bz;

    // Interrupts come straight from flops so reset drops them immediately.
    assign irq = exp_q & ien_q & ~nsel_q;
    assign nmi = exp_q & ien_q & nsel_q;

    // Combinational read mux over the register window.
    always_comb begin
        rdData = 8'h00;
        case (offset)
            OFF_CTRL:     rdData = {3'b000, wdogBit, nsel_q, ien_q, auto_q, en_q};
            OFF_PRESCALE: rdData = prescale_q;
            OFF_RELOADLO: rdData = reloadLo_q;
            OFF_RELOADHI: rdData = reloadHi_q;
            OFF_COUNTLO:  rdData = count_q[7:0];
            OFF_COUNTHI:  rdData = snap_q;
            OFF_STATUS:   rdData = {6'b000000, ovf_q, exp_q};
            OFF_ID:       rdData = ID_VALUE;
            default:      rdData = 8'h00;
        endcase
    end

    // Next-state logic for the prescaler, counter and register file.
    // Ordering inside the enabled branch encodes the collision rules: a
    // COUNT_LO write beats a tick, a CTRL write clearing EN swallows the
    // tick, and an expiry set of EXP beats a STATUS clear on the same edge.
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        ien_d      = ien_q;
        nsel_d     = nsel_q;
        prescale_d = prescale_q;
        reloadLo_d = reloadLo_q;
        reloadHi_d = reloadHi_q;
        count_d    = count_q;
        snap_d     = snap_q;
        exp_d      = exp_q;
        ovf_d      = ovf_q;
        preCnt_d   = preCnt_q;
        tick       = 1'b0;
        tickLive   = 1'b0;
        expiry     = 1'b0;

        if (clk_en) begin
            if (en_q) begin
                if (preCnt_q == prescale_q) begin
                    tick     = 1'b1;
                    preCnt_d = 8'd0;
                end else begin
                    preCnt_d = preCnt_q + 8'd1;
                end
            end else begin
                preCnt_d = 8'd0;
            end

            if (ctrlWr) begin
                en_d   = wrData[0];
                auto_d = wrData[1];
                ien_d  = wrData[2];
                nsel_d = wrData[3];
                if (!wrData[0]) begin
                    preCnt_d = 8'd0;
                end
            end
            if (prescaleWr) begin
                prescale_d = wrData;
            end
            if (reloadLoWr) begin
                reloadLo_d = wrData;
            end
            if (reloadHiWr) begin
                reloadHi_d = wrData;
            end
            if (statusWr) begin
                exp_d = exp_q & ~wrData[0];
                ovf_d = ovf_q & ~wrData[1];
            end
            if (countLoRd) begin
                snap_d = count_q[15:8];
            end

            tickLive = tick && !countLoWr && !(ctrlWr && !wrData[0]);

            if (countLoWr) begin
                count_d  = {reloadHi_q, reloadLo_q};
                preCnt_d = 8'd0;
            end else if (tickLive) begin
                if (count_q != 16'd0) begin
                    count_d = count_q - 16'd1;
                end else begin
                    expiry = 1'b1;
                    exp_d  = 1'b1;
                    if (exp_q) begin
                        ovf_d = 1'b1;
                    end
                    if (auto_q) begin
                        count_d = {reloadHi_q, reloadLo_q};
                    end else begin
                        en_d = 1'b0;
                    end
                end
            end
        end
    end

    // State register; clk_en is already folded into every _d value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ien_q      <= 1'b0;
            nsel_q     <= 1'b0;
            prescale_q <= 8'd0;
            reloadLo_q <= 8'd0;
            reloadHi_q <= 8'd0;
            count_q    <= 16'd0;
            snap_q     <= 8'd0;
            exp_q      <= 1'b0;
            ovf_q      <= 1'b0;
            preCnt_q   <= 8'd0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            ien_q      <= ien_d;
            nsel_q     <= nsel_d;
            prescale_q <= prescale_d;
            reloadLo_q <= reloadLo_d;
            reloadHi_q <= reloadHi_d;
            count_q    <= count_d;
            snap_q     <= snap_d;
            exp_q      <= exp_d;
            ovf_q      <= ovf_d;
            preCnt_q   <= preCnt_d;
        end
    end

`ifdef BUS_TIMER_WATCHDOG_EN
    logic wdog_q,     wdog_d;
    logic wdogPend_q, wdogPend_d;
    logic rstReq_q,   rstReq_d;

    assign wdogBit = wdog_q;
    assign rst_req = rstReq_q;

    // WDOG is set-only from the bus. An expiry while armed is remembered
    // for one enabled edge, then presented on rst_req for one enabled cycle.
    // The kick needs no logic here: a COUNT_LO write reloads the counter.
    always_comb begin
        wdog_d     = wdog_q;
        wdogPend_d = wdogPend_q;
        rstReq_d   = rstReq_q;
        if (clk_en) begin
            if (ctrlWr && wrData[4]) begin
                wdog_d = 1'b1;
            end
            wdogPend_d = expiry && wdog_q;
            rstReq_d   = wdogPend_q;
        end
    end

    // Watchdog state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q     <= 1'b0;
            wdogPend_q <= 1'b0;
            rstReq_q   <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            wdogPend_q <= wdogPend_d;
            rstReq_q   <= rstReq_d;
        end
    end
`else
    assign wdogBit = 1'b0;
    assign rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_bus_timer_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_timer_responder
//
// Directed bench for bus_timer_responder. Stimulus tasks drive one bus cycle
// at a time and push the hand-computed expectation for that cycle into a
// scoreboard queue; a monitor on the falling clock edge pops and compares
// every pending entry against the bus or the interrupt pins.
// ---------------------------------------------------------------------------
module tb_bus_timer_responder;

    localparam logic [15:0] BASE      = 16'h8000;
    localparam logic [15:0] IDLE_ADDR = 16'h0200;

    localparam int K_DATA   = 0;
    localparam int K_IRQ    = 1;
    localparam int K_NMI    = 2;
    localparam int K_RSTREQ = 3;

`ifdef BUS_TIMER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [7:0] expected;
        string      name;
    } sbEntry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clkEn;
    logic [15:0] addr;
    logic        wr;
    logic        tbDrive;
    logic [7:0]  tbData;
    wire  [7:0]  data;
    logic        irq;
    logic        nmi;
    logic        rstReq;

    sbEntry_t    sb[$];
    bit          probe = 1'b0;
    int          testsRun = 0;
    int          testsFailed = 0;
    sbEntry_t    monEntry;
    logic [7:0]  monActual;

    assign data = tbDrive ? tbData : 8'bz;

    bus_timer_responder #(
        .BASE_ADDR(16'h8000),
        .ID_VALUE (8'hC7)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clkEn),
        .addr   (addr),
        .data   (data),
        .wr     (wr),
        .irq    (irq),
        .nmi    (nmi),
        .rst_req(rstReq)
    );

    always #5 clk = ~clk;

    // Monitor: whenever a cycle carries expectations, compare them all.
    always @(negedge clk) begin
        if (probe) begin
            while (sb.size() > 0) begin
                monEntry = sb.pop_front();
                case (monEntry.kind)
                    K_DATA:   monActual = data;
                    K_IRQ:    monActual = {7'b0, irq};
                    K_NMI:    monActual = {7'b0, nmi};
                    K_RSTREQ: monActual = {7'b0, rstReq};
                    default:  monActual = 8'h00;
                endcase
                testsRun++;
                if (monActual !== monEntry.expected) begin
                    testsFailed++;
                    $display("[TB] FAIL %s: got %02h, expected %02h",
                             monEntry.name, monActual, monEntry.expected);
                end
            end
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: still running at %0t, expected finish before 200000", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [15:0] a, input logic w,
                                 input logic drv, input logic [7:0] v);
        addr    = a;
        wr      = w;
        tbDrive = drv;
        tbData  = v;
    endtask

    task automatic checkOutput(input int kind, input logic [7:0] expected,
                               input string name);
        sbEntry_t ent;
        ent.kind     = kind;
        ent.expected = expected;
        ent.name     = name;
        sb.push_back(ent);
        probe = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        probe = 1'b0;
        applyStimulus(IDLE_ADDR, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic writeReg(input logic [2:0] off, input logic [7:0] val);
        applyStimulus(BASE | {13'd0, off}, 1'b1, 1'b1, val);
        step();
    endtask

    task automatic readReg(input logic [2:0] off, input logic [7:0] expected,
                           input string name);
        applyStimulus(BASE | {13'd0, off}, 1'b0, 1'b0, 8'h00);
        checkOutput(K_DATA, expected, name);
        step();
    endtask

    task automatic checkSignal(input int kind, input logic [7:0] expected,
                               input string name);
        checkOutput(kind, expected, name);
        step();
    endtask

    initial begin
        rst   = 1'b1;
        clkEn = 1'b1;
        applyStimulus(IDLE_ADDR, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values across the whole window
        for (int i = 0; i < 8; i++) begin
            readReg(i[2:0], (i == 7) ? 8'hC7 : 8'h00, $sformatf("reset read off%0d", i));
        end
        checkOutput(K_IRQ, 8'h00, "reset irq");
        checkOutput(K_NMI, 8'h00, "reset nmi");
        checkOutput(K_RSTREQ, 8'h00, "reset rst_req");
        step();
        // Bench drives A5 on an unselected read; the DUT must stay off the bus
        applyStimulus(IDLE_ADDR, 1'b0, 1'b1, 8'hA5);
        checkOutput(K_DATA, 8'hA5, "bus released when unselected");
        step();

        // One-shot expiry
        writeReg(3'd2, 8'h03);
        writeReg(3'd3, 8'h00);
        writeReg(3'd4, 8'h00);
        writeReg(3'd0, 8'h05);
        readReg(3'd4, 8'h03, "oneshot count before first tick");
        readReg(3'd4, 8'h02, "oneshot count 2");
        readReg(3'd4, 8'h01, "oneshot count 1");
        applyStimulus(BASE | 16'd4, 1'b0, 1'b0, 8'h00);
        checkOutput(K_DATA, 8'h00, "oneshot count 0");
        checkOutput(K_IRQ, 8'h00, "oneshot irq before expiry");
        step();
        applyStimulus(BASE | 16'd6, 1'b0, 1'b0, 8'h00);
        checkOutput(K_DATA, 8'h01, "oneshot status EXP");
        checkOutput(K_IRQ, 8'h01, "oneshot irq after expiry");
        step();
        readReg(3'd0, 8'h04, "oneshot EN cleared");
        readReg(3'd4, 8'h00, "oneshot count holds 0");
        writeReg(3'd6, 8'h01);
        checkSignal(K_IRQ, 8'h00, "oneshot irq after W1C");

        // Auto-reload with prescale 1: period 6
        writeReg(3'd1, 8'h01);
        writeReg(3'd2, 8'h02);
        writeReg(3'd4, 8'h00);
        writeReg(3'd0, 8'h07);
        idle(5);
        readReg(3'd6, 8'h00, "auto status before first expiry");
        applyStimulus(BASE | 16'd6, 1'b0, 1'b0, 8'h00);
        checkOutput(K_DATA, 8'h01, "auto first expiry");
        checkOutput(K_IRQ, 8'h01, "auto irq");
        step();
        idle(4);
        readReg(3'd6, 8'h01, "auto status before second expiry");
        readReg(3'd6, 8'h03, "auto second expiry sets OVF");
        writeReg(3'd6, 8'h03);
        applyStimulus(BASE | 16'd6, 1'b0, 1'b0, 8'h00);
        checkOutput(K_DATA, 8'h00, "auto status cleared");
        checkOutput(K_IRQ, 8'h00, "auto irq dropped");
        step();
        writeReg(3'd0, 8'h00);

        // NMI routing, W1C racing expiry, CTRL-off discarding a tick
        writeReg(3'd1, 8'h00);
        writeReg(3'd2, 8'h02);
        writeReg(3'd4, 8'h00);
        writeReg(3'd0, 8'h0F);
        idle(2);
        writeReg(3'd6, 8'h01);
        applyStimulus(BASE | 16'd6, 1'b0, 1'b0, 8'h00);
        checkOutput(K_DATA, 8'h01, "race EXP survives W1C");
        checkOutput(K_NMI, 8'h01, "race nmi");
        checkOutput(K_IRQ, 8'h00, "race irq masked by NSEL");
        step();
        writeReg(3'd6, 8'h01);
        writeReg(3'd0, 8'h00);
        applyStimulus(BASE | 16'd6, 1'b0, 1'b0, 8'h00);
        checkOutput(K_DATA, 8'h00, "ctrl-off tick gives no expiry");
        checkOutput(K_NMI, 8'h00, "nmi low after clear");
        step();
        readReg(3'd4, 8'h00, "ctrl-off tick leaves count");

        // 16-bit snapshot, then clk_en freeze
        writeReg(3'd2, 8'h00);
        writeReg(3'd3, 8'h01);
        writeReg(3'd4, 8'h00);
        writeReg(3'd0, 8'h01);
        readReg(3'd4, 8'h00, "snapshot count lo");
        readReg(3'd5, 8'h01, "snapshot count hi");
        readReg(3'd4, 8'hFE, "snapshot lo after decrements");
        readReg(3'd5, 8'h00, "snapshot hi refreshed");
        clkEn = 1'b0;
        writeReg(3'd0, 8'h00);
        readReg(3'd4, 8'hFC, "clk_en low freezes count");
        readReg(3'd0, 8'h01, "clk_en low ignores write");
        clkEn = 1'b1;
        writeReg(3'd0, 8'h00);

        // Watchdog (or its absence)
        writeReg(3'd6, 8'h03);
        writeReg(3'd2, 8'h01);
        writeReg(3'd3, 8'h00);
        writeReg(3'd4, 8'h00);
        writeReg(3'd0, 8'h11);
        for (int c = 0; c < 6; c++) begin
            checkSignal(K_RSTREQ, (WD && c == 3) ? 8'h01 : 8'h00,
                        $sformatf("rst_req cycle %0d", c));
        end
        readReg(3'd0, WD ? 8'h10 : 8'h00, "ctrl after wdog expiry");
        writeReg(3'd0, 8'h00);
        readReg(3'd0, WD ? 8'h10 : 8'h00, "wdog bit sticky");

        // Asynchronous reset mid-count
        writeReg(3'd6, 8'h03);
        writeReg(3'd1, 8'h00);
        writeReg(3'd2, 8'h02);
        writeReg(3'd4, 8'h00);
        writeReg(3'd0, 8'h07);
        idle(3);
        checkSignal(K_IRQ, 8'h01, "irq before reset");
        applyStimulus(BASE | 16'd0, 1'b0, 1'b0, 8'h00);
        checkOutput(K_DATA, 8'h00, "ctrl async reset");
        checkOutput(K_IRQ, 8'h00, "irq async reset");
        checkOutput(K_RSTREQ, 8'h00, "rst_req async reset");
        #1;
        rst = 1'b1;
        step();
        readReg(3'd4, 8'h00, "count in reset");
        rst = 1'b0;
        readReg(3'd6, 8'h00, "status after reset");

        @(negedge clk);
        testsRun++;
        if (sb.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
